// File: rtl/fifo_pkg.sv
// Shared constants and pointer helper for the FIFO read-side controller.
package fifo_pkg;

    localparam int RAM_RD_LAT = 2;
    localparam int DEF_WIDTH  = 8;
    localparam int DEF_ADDR   = 13;

    // Modular difference a - b over the low w bits (w <= 32).
    function automatic logic [31:0] ptr_diff(input logic [31:0] a,
                                             input logic [31:0] b,
                                             input int unsigned w);
        logic [31:0] mask;
        mask = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
        return (a - b) & mask;
    endfunction

endpackage

// File: rtl/fifo_rd_ctrl_if.sv
// RAM read port and downstream valid/ready stream of the FIFO read side.
interface fifo_rd_ctrl_if
    import fifo_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int ADDR  = DEF_ADDR
) ();

    logic             rd_en;
    logic [ADDR-1:0]  rd_addr;
    logic [WIDTH-1:0] rd_dataout;
    logic [WIDTH-1:0] m_data;
    logic             m_valid;
    logic             m_ready;

    modport master (
        output rd_en, rd_addr, m_data, m_valid,
        input  rd_dataout, m_ready
    );

    modport slave (
        input  rd_en, rd_addr, m_data, m_valid,
        output rd_dataout, m_ready
    );

endinterface

// File: rtl/rd_out_buf.sv
// Small shift-register FIFO landing RAM read data; entry 0 is the registered stream head.
module rd_out_buf #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             rd_clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic             valid
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_nxt;
    logic [CW-1:0]    wr_slot;

    always_comb begin
        cnt_nxt = cnt + CW'(push) - CW'(pop);
        wr_slot = pop ? (cnt - CW'(1)) : cnt;
    end

    always_ff @(posedge rd_clk) begin
        if (reset) begin
            cnt   <= '0;
            valid <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (pop) begin
                for (int i = 0; i < DEPTH - 1; i++) mem[i] <= mem[i + 1];
            end
            // The credit scheme upstream keeps push from ever landing on a full buffer.
            if (push && (wr_slot < CW'(DEPTH))) mem[wr_slot[IW-1:0]] <= din;
            cnt   <= cnt_nxt;
            valid <= (cnt_nxt != '0);
        end
    end

    assign head = mem[0];

endmodule

// File: rtl/fifo_rd_ctrl.sv
// FIFO read-side controller: issues RAM reads against a credit count and streams the
// returned words out through a registered buffer.
module fifo_rd_ctrl
    import fifo_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int ADDR      = DEF_ADDR,
    parameter int BUF_DEPTH = 4
) (
    input  logic            rd_clk,
    input  logic            reset,
    input  logic [ADDR:0]   wr_ptr,
    output logic [ADDR:0]   rd_ptr,
    output logic            empty,
    output logic [ADDR:0]   rd_count,
    fifo_rd_ctrl_if.master  bus
);

    localparam int OW = $clog2(BUF_DEPTH + 1);

    logic [OW-1:0]         occ;
    logic [OW-1:0]         occ_nxt;
    logic [RAM_RD_LAT-1:0] tags;
    logic [ADDR:0]         rd_ptr_nxt;
    logic                  issue;
    logic                  buf_push;
    logic                  buf_pop;

    // occ covers in-flight plus buffered words, so an issue always has a buffer slot waiting.
    assign issue    = !empty && (occ < OW'(BUF_DEPTH));
    assign buf_push = tags[RAM_RD_LAT-1];
    assign buf_pop  = bus.m_valid && bus.m_ready;

    assign bus.rd_en   = issue;
    assign bus.rd_addr = rd_ptr[ADDR-1:0];

    always_comb begin
        rd_ptr_nxt = rd_ptr + (ADDR+1)'(issue);
        occ_nxt    = occ + OW'(issue) - OW'(buf_pop);
    end

    always_ff @(posedge rd_clk) begin
        if (reset) begin
            rd_ptr   <= '0;
            occ      <= '0;
            tags     <= '0;
            empty    <= 1'b1;
            rd_count <= '0;
        end else begin
            rd_ptr   <= rd_ptr_nxt;
            occ      <= occ_nxt;
            tags     <= {tags[RAM_RD_LAT-2:0], issue};
            empty    <= (wr_ptr == rd_ptr_nxt);
            rd_count <= (ADDR+1)'(ptr_diff(32'(wr_ptr), 32'(rd_ptr_nxt), ADDR + 1));
        end
    end

    rd_out_buf #(
        .WIDTH (WIDTH),
        .DEPTH (BUF_DEPTH)
    ) u_buf (
        .rd_clk (rd_clk),
        .reset  (reset),
        .push   (buf_push),
        .pop    (buf_pop),
        .din    (bus.rd_dataout),
        .head   (bus.m_data),
        .valid  (bus.m_valid)
    );

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Bench for fifo_rd_ctrl: RAM models with a 2-cycle read pipe, scoreboard of written words.
module tb_fifo_rd_ctrl;
    import fifo_pkg::*;

    localparam int W  = 8;
    localparam int A  = 13;
    localparam int A3 = 3;
    localparam int BD = 4;

    logic rd_clk = 1'b0;
    always #5 rd_clk = ~rd_clk;

    logic          reset, reset3;
    logic [A:0]    wr_ptr, rd_ptr, rd_count;
    logic          empty;
    logic [A3:0]   wr_ptr3, rd_ptr3, rd_count3;
    logic          empty3;

    fifo_rd_ctrl_if #(.WIDTH(W), .ADDR(A))  bus  ();
    fifo_rd_ctrl_if #(.WIDTH(W), .ADDR(A3)) bus3 ();

    fifo_rd_ctrl #(.WIDTH(W), .ADDR(A), .BUF_DEPTH(BD)) dut (
        .rd_clk (rd_clk), .reset (reset), .wr_ptr (wr_ptr), .rd_ptr (rd_ptr),
        .empty (empty), .rd_count (rd_count), .bus (bus.master)
    );

    fifo_rd_ctrl #(.WIDTH(W), .ADDR(A3), .BUF_DEPTH(BD)) dut3 (
        .rd_clk (rd_clk), .reset (reset3), .wr_ptr (wr_ptr3), .rd_ptr (rd_ptr3),
        .empty (empty3), .rd_count (rd_count3), .bus (bus3.master)
    );

    logic [W-1:0] mem  [2**A];
    logic [W-1:0] mem3 [2**A3];
    logic [W-1:0] pipe1, pipe1_3;

    always @(posedge rd_clk) begin
        pipe1           <= mem[bus.rd_addr];
        bus.rd_dataout  <= pipe1;
        pipe1_3         <= mem3[bus3.rd_addr];
        bus3.rd_dataout <= pipe1_3;
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp_q3[$];

    int cyc = 0, beats = 0, first_beat = -1, last_beat = -1, rden_cnt = 0, ovf_cnt = 0;
    logic         stalled = 1'b0;
    logic [W-1:0] stall_data = '0;

    always @(negedge rd_clk) begin
        cyc++;
        if (bus.rd_en) rden_cnt++;
        if (dut.u_buf.cnt == BD && dut.buf_push && !dut.buf_pop) ovf_cnt++;
        if (dut3.u_buf.cnt == BD && dut3.buf_push && !dut3.buf_pop) ovf_cnt++;
        if (stalled && bus.m_valid) chk("stall_hold", 32'(bus.m_data), 32'(stall_data));
        if (bus.m_valid && bus.m_ready) begin
            beats++;
            if (first_beat < 0) first_beat = cyc;
            last_beat = cyc;
            if (exp_q.size() == 0) chk("sb_underflow", exp_q.size(), 1);
            else chk("data", 32'(bus.m_data), 32'(exp_q.pop_front()));
        end
        stalled    = bus.m_valid && !bus.m_ready;
        stall_data = bus.m_data;
    end

    int beats3 = 0, addr_wraps = 0, ptr_wraps = 0;
    logic [A3-1:0] prev_addr3 = '0;
    logic [A3:0]   prev_ptr3  = '0;

    always @(negedge rd_clk) begin
        if (bus3.m_valid && bus3.m_ready) begin
            beats3++;
            if (exp_q3.size() == 0) chk("sb3_underflow", exp_q3.size(), 1);
            else chk("data3", 32'(bus3.m_data), 32'(exp_q3.pop_front()));
        end
        if (prev_addr3 == 3'd7 && bus3.rd_addr == 3'd0) addr_wraps++;
        if (prev_ptr3 == 4'd15 && rd_ptr3 == 4'd0) ptr_wraps++;
        prev_addr3 = bus3.rd_addr;
        prev_ptr3  = rd_ptr3;
    end

    task automatic sample();
        @(negedge rd_clk);
        #1;
    endtask

    task automatic drive();
        @(posedge rd_clk);
        #1;
    endtask

    task automatic write_word(input logic [W-1:0] d);
        drive();
        mem[wr_ptr[A-1:0]] = d;
        exp_q.push_back(d);
        wr_ptr = wr_ptr + 1'b1;
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || bus.m_valid) && n < budget) begin
            sample();
            n++;
        end
        chk("drain_left", exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [A3:0] space3;
        int n_wr, budget;
        logic [W-1:0] d;

        // Reset with wr_ptr=5 already published by the write side
        reset = 1'b1; reset3 = 1'b1;
        wr_ptr = 5; wr_ptr3 = '0;
        bus.m_ready = 1'b1; bus3.m_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            mem[i] = 8'h10 + 8'(i);
            exp_q.push_back(8'h10 + 8'(i));
        end
        repeat (3) sample();
        chk("rst_rd_en",   32'(bus.rd_en), 0);
        chk("rst_rd_ptr",  32'(rd_ptr), 0);
        chk("rst_rd_addr", 32'(bus.rd_addr), 0);
        chk("rst_m_valid", 32'(bus.m_valid), 0);
        chk("rst_m_data",  32'(bus.m_data), 0);
        chk("rst_empty",   32'(empty), 1);
        chk("rst_count",   32'(rd_count), 0);
        drive();
        reset = 1'b0; reset3 = 1'b0;
        sample();
        chk("pre_edge_rd_en", 32'(bus.rd_en), 0);
        sample();
        chk("post_rst_empty", 32'(empty), 0);
        chk("post_rst_count", 32'(rd_count), 5);
        chk("post_rst_rd_en", 32'(bus.rd_en), 1);
        wait_drain(40);
        chk("t1_rd_ptr", 32'(rd_ptr), 5);
        chk("t1_empty",  32'(empty), 1);

        // Single word latency from pointer 0
        drive();
        reset = 1'b1; wr_ptr = '0;
        drive();
        reset = 1'b0;
        write_word(8'hA5);
        sample();
        chk("t2_c0_rd_en", 32'(bus.rd_en), 0);
        sample();
        chk("t2_n_rd_en",   32'(bus.rd_en), 1);
        chk("t2_n_rd_addr", 32'(bus.rd_addr), 0);
        chk("t2_n_count",   32'(rd_count), 1);
        sample();
        chk("t2_n1_empty",   32'(empty), 1);
        chk("t2_n1_rd_en",   32'(bus.rd_en), 0);
        chk("t2_n1_m_valid", 32'(bus.m_valid), 0);
        sample();
        chk("t2_n2_m_valid", 32'(bus.m_valid), 0);
        sample();
        chk("t2_n3_m_valid", 32'(bus.m_valid), 1);
        chk("t2_n3_m_data",  32'(bus.m_data), 32'h A5);
        wait_drain(20);

        // Back-to-back burst
        beats = 0; first_beat = -1; last_beat = -1;
        for (int i = 0; i < 16; i++) write_word(8'(i));
        wait_drain(60);
        chk("t3_beats", beats, 16);
        chk("t3_span",  last_beat - first_beat, 15);
        chk("t3_count", 32'(rd_count), 0);
        chk("t3_empty", 32'(empty), 1);

        // Stalled stream: credits cap issues at BUF_DEPTH
        drive();
        bus.m_ready = 1'b0;
        rden_cnt = 0;
        for (int i = 0; i < 10; i++) write_word(8'h40 + 8'(i));
        repeat (8) sample();
        chk("t4_rden_pulses", rden_cnt, 4);
        chk("t4_count",   32'(rd_count), 6);
        chk("t4_occ",     32'(dut.occ), 4);
        chk("t4_m_valid", 32'(bus.m_valid), 1);
        chk("t4_head",    32'(bus.m_data), 32'(exp_q[0]));
        drive();
        bus.m_ready = 1'b1;
        beats = 0;
        wait_drain(60);
        chk("t4_beats", beats, 10);
        chk("t4_empty", 32'(empty), 1);

        // Reset with two words in flight and two buffered
        drive();
        bus.m_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            mem[wr_ptr[A-1:0] + A'(i)] = 8'h60 + 8'(i);
            exp_q.push_back(8'h60 + 8'(i));
        end
        wr_ptr = wr_ptr + 6;
        sample();
        sample();
        chk("t6_n_rd_en", 32'(bus.rd_en), 1);
        repeat (4) sample();
        chk("t6_buffered", 32'(dut.u_buf.cnt), 2);
        chk("t6_occ",      32'(dut.occ), 4);
        reset = 1'b1; wr_ptr = '0;
        exp_q.delete();
        drive();
        reset = 1'b0; bus.m_ready = 1'b1;
        sample();
        chk("t6_rst_m_valid", 32'(bus.m_valid), 0);
        chk("t6_rst_rd_ptr",  32'(rd_ptr), 0);
        chk("t6_rst_empty",   32'(empty), 1);
        for (int i = 0; i < 5; i++) begin
            sample();
            chk("t6_no_stale", 32'(bus.m_valid), 0);
        end
        for (int i = 0; i < 3; i++) write_word(8'h71 + 8'(i));
        wait_drain(30);
        chk("t6_rd_ptr", 32'(rd_ptr), 3);

        // Small RAM: pointer and address wrap under random backpressure
        n_wr = 0; budget = 0;
        while ((n_wr < 20 || exp_q3.size() != 0) && budget < 600) begin
            drive();
            budget++;
            bus3.m_ready = 1'($urandom_range(0, 1));
            space3 = wr_ptr3 - rd_ptr3;
            if (n_wr < 20 && space3 < 4'd8) begin
                d = 8'($urandom);
                mem3[wr_ptr3[A3-1:0]] = d;
                exp_q3.push_back(d);
                wr_ptr3 = wr_ptr3 + 1'b1;
                n_wr++;
            end
        end
        bus3.m_ready = 1'b1;
        repeat (3) sample();
        chk("t5_written",    n_wr, 20);
        chk("t5_left",       exp_q3.size(), 0);
        chk("t5_beats",      beats3, 20);
        chk("t5_addr_wraps", addr_wraps, 2);
        chk("t5_ptr_wraps",  ptr_wraps, 1);
        chk("t5_rd_ptr",     32'(rd_ptr3), 4);
        chk("t5_empty",      32'(empty3), 1);
        chk("t5_count",      32'(rd_count3), 0);

        chk("buf_overflow", ovf_cnt, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
